// File: rtl/window_gen_3x3_pkg.sv
// Shared constants and types for the 3x3 window generator
// and the kernel blocks it feeds.
package window_gen_3x3_pkg;
  localparam int PIX_W_DEF = 8;
  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;
  localparam int COL_W_DEF = $clog2(IMG_W_DEF);
  localparam int ROW_W_DEF = $clog2(IMG_H_DEF);

  typedef logic [PIX_W_DEF-1:0] pix_t;
  // Index 0 = p1 (top-left), index 8 = p9 (bottom-right)
  typedef pix_t [8:0] window_t;
endpackage

// File: rtl/window_gen_3x3_line_buf.sv
// Single-port line memory: combinational read, write on clock,
// so a same-address read in the write cycle sees the old data.
module window_gen_3x3_line_buf #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end
endmodule

// File: rtl/window_gen_3x3.sv
// Raster pixel stream to 3x3 neighbourhood generator; emits
// interior windows only, one output register with valid/ready.
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic [PIX_W-1:0] p9,
  output logic             frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [RW-1:0] ROW_TWO = RW'(2);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [8:0][PIX_W-1:0] win_q, win_d;
  logic ov_q, ov_d;
  logic fd_q, fd_d;

  logic acc, qual, col_last, row_last;
  logic [2*PIX_W-1:0] lb_rd, lb_wr;
  logic [PIX_W-1:0] top_pix, mid_pix;

  assign in_ready = !ov_q | out_ready;
  assign acc      = in_valid & in_ready;
  assign col_last = (col_q == COL_MAX);
  assign row_last = (row_q == ROW_MAX);
  assign qual     = acc & (row_q >= ROW_TWO)
                  & (col_q >= COL_TWO);

  // High half is the older line: it takes the old lb0 value
  assign top_pix = lb_rd[2*PIX_W-1:PIX_W];
  assign mid_pix = lb_rd[PIX_W-1:0];
  assign lb_wr   = {mid_pix, in_pix};

  window_gen_3x3_line_buf #(
    .DEPTH(IMG_W),
    .WIDTH(2*PIX_W),
    .AW   (CW)
  ) u_lb (
    .clk  (clk),
    .we   (acc),
    .addr (col_q),
    .wdata(lb_wr),
    .rdata(lb_rd)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    fd_d  = 1'b0;
    ov_d  = ov_q;
    if (out_ready) ov_d = 1'b0;
    if (acc) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = top_pix;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = mid_pix;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = in_pix;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
        fd_d  = row_last;
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (qual) ov_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '0;
      ov_q  <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      ov_q  <= ov_d;
      fd_q  <= fd_d;
    end
  end

  assign out_valid  = ov_q;
  assign frame_done = fd_q;
  assign p1 = win_q[0];
  assign p2 = win_q[1];
  assign p3 = win_q[2];
  assign p4 = win_q[3];
  assign p5 = win_q[4];
  assign p6 = win_q[5];
  assign p7 = win_q[6];
  assign p8 = win_q[7];
  assign p9 = win_q[8];
endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: three image geometries checked
// against a frame-array reference model.
module tb_window_gen_3x3;
  localparam int WS [3] = '{4, 16, 3};
  localparam int HS [3] = '{4, 8, 3};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv [3];
  logic       ir [3];
  logic       ov [3];
  logic       ordy [3];
  logic       fd [3];
  logic [7:0] ip [3];
  logic [7:0] p  [3][9];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    window_gen_3x3 #(
      .IMG_W(WS[g]), .IMG_H(HS[g]), .PIX_W(8)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(iv[g]), .in_ready(ir[g]), .in_pix(ip[g]),
      .out_valid(ov[g]), .out_ready(ordy[g]),
      .p1(p[g][0]), .p2(p[g][1]), .p3(p[g][2]),
      .p4(p[g][3]), .p5(p[g][4]), .p6(p[g][5]),
      .p7(p[g][6]), .p8(p[g][7]), .p9(p[g][8]),
      .frame_done(fd[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int mr, mc, nfd;
  logic [7:0] img [8][16];
  logic [71:0] exp_q [$];
  logic [71:0] got_q [$];
  logic ov_m, fd_m;
  bit kern_on;

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [71:0] pack(int k);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[71-8*i -: 8] = p[k][i];
    return w;
  endfunction

  function automatic logic [71:0] win_at(int r, int c);
    logic [71:0] w;
    for (int i = 0; i < 9; i++)
      w[71-8*i -: 8] = img[r-2+i/3][c-2+i%3];
    return w;
  endfunction

  function automatic int kern(logic [71:0] w);
    int b [9];
    for (int i = 0; i < 9; i++) b[i] = int'(w[71-8*i -: 8]);
    return 2*(b[0]+b[4]+b[8]) - (b[1]+b[2]+b[3]+b[5]+b[6]+b[7]);
  endfunction

  task automatic cyc(input int k, input logic v, input logic [7:0] px,
                     input logic r, output logic took);
    logic cons, qual;
    logic [71:0] w;
    @(negedge clk);
    chk("out_valid", 72'(ov[k]), 72'(ov_m));
    chk("frame_done", 72'(fd[k]), 72'(fd_m));
    if (fd[k] === 1'b1) nfd++;
    iv[k] = v; ip[k] = px; ordy[k] = r;
    #1;
    chk("in_ready", 72'(ir[k]), 72'(!ov_m || r));
    took = iv[k] && ir[k];
    cons = ov[k] && r;
    if (cons) begin
      w = pack(k);
      chk("window_expected", 72'(exp_q.size() != 0), 72'(1));
      if (exp_q.size() != 0) chk("window", w, exp_q.pop_front());
      if (kern_on) chk("kernel_zero", 72'(kern(w)), 72'(0));
      got_q.push_back(w);
    end
    qual = 1'b0;
    fd_m = 1'b0;
    if (took) begin
      img[mr][mc] = px;
      if (mr >= 2 && mc >= 2) begin
        exp_q.push_back(win_at(mr, mc));
        qual = 1'b1;
      end
      fd_m = (mr == HS[k]-1 && mc == WS[k]-1);
      if (mc == WS[k]-1) begin
        mc = 0;
        mr = (mr == HS[k]-1) ? 0 : mr + 1;
      end else mc++;
    end
    ov_m = qual ? 1'b1 : (cons ? 1'b0 : ov_m);
  endtask

  task automatic send(input int k, input int base, input bit rpix,
                      input bit rhs, input int stall, input int n);
    int idx = 0;
    int guard = 0;
    logic [7:0] px;
    logic took, v, r;
    logic [71:0] w;
    px = rpix ? 8'($urandom) : 8'(base);
    while (idx < n) begin
      if (++guard > 4000) begin
        chk("frame_timeout", 72'(idx), 72'(n));
        break;
      end
      if (stall > 0 && ov_m) begin
        for (int i = 0; i < stall; i++) begin
          cyc(k, 1'b1, px, 1'b0, took);
          chk("stall_in_ready", 72'(ir[k]), 72'(0));
          if (i == 0) begin
            w = pack(k);
            chk("stall_front", w, exp_q[0]);
          end else chk("stall_hold", pack(k), w);
          if (took) begin
            idx++;
            px = rpix ? 8'($urandom) : 8'(base + idx);
          end
        end
        stall = 0;
      end
      v = rhs ? 1'($urandom) : 1'b1;
      r = rhs ? 1'($urandom) : 1'b1;
      cyc(k, v, px, r, took);
      if (took) begin
        idx++;
        px = rpix ? 8'($urandom) : 8'(base + idx);
      end
    end
  endtask

  task automatic drain(input int k, input int n);
    logic took;
    repeat (n) cyc(k, 1'b0, 8'h00, 1'b1, took);
  endtask

  task automatic do_rst(input int k);
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      iv[j] = 1'b0; ordy[j] = 1'b0; ip[j] = '0;
    end
    @(negedge clk);
    rst = 1'b0;
    mr = 0; mc = 0;
    exp_q.delete();
    ov_m = 1'b0; fd_m = 1'b0;
    #1;
    chk("rst_out_valid", 72'(ov[k]), 72'(0));
    chk("rst_frame_done", 72'(fd[k]), 72'(0));
    chk("rst_in_ready", 72'(ir[k]), 72'(1));
    chk("rst_window", pack(k), 72'(0));
  endtask

  task automatic begin_test(input bit kon);
    got_q.delete();
    nfd = 0;
    kern_on = kon;
  endtask

  task automatic end_test(input string tag, input int nw, input int nf);
    chk({tag, "_windows"}, 72'(got_q.size()), 72'(nw));
    chk({tag, "_frame_done"}, 72'(nfd), 72'(nf));
    chk({tag, "_leftover"}, 72'(exp_q.size()), 72'(0));
  endtask

  localparam logic [71:0] R4_FIRST = 72'h00_01_02_04_05_06_08_09_0A;
  localparam logic [71:0] R4_LAST  = 72'h05_06_07_09_0A_0B_0D_0E_0F;

  initial begin
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      iv[j] = 1'b0; ordy[j] = 1'b0; ip[j] = '0;
    end
    do_rst(0);

    begin_test(1'b1);
    send(0, 0, 1'b0, 1'b0, 0, 16);
    drain(0, 4);
    end_test("ramp", 4, 1);
    chk("ramp_first", got_q[0], R4_FIRST);
    chk("ramp_last", got_q[$], R4_LAST);

    begin_test(1'b1);
    send(0, 0, 1'b0, 1'b0, 5, 16);
    drain(0, 4);
    end_test("stall", 4, 1);
    chk("stall_first", got_q[0], R4_FIRST);
    chk("stall_last", got_q[$], R4_LAST);

    begin_test(1'b1);
    send(0, 0, 1'b0, 1'b0, 0, 16);
    send(0, 16, 1'b0, 1'b0, 0, 16);
    drain(0, 4);
    end_test("b2b", 8, 2);
    chk("b2b_f2_first", got_q[4], 72'h10_11_12_14_15_16_18_19_1A);

    begin_test(1'b1);
    send(0, 0, 1'b0, 1'b0, 0, 10);
    drain(0, 2);
    chk("pre_rst_windows", 72'(got_q.size()), 72'(0));
    do_rst(0);
    begin_test(1'b1);
    send(0, 100, 1'b0, 1'b0, 0, 16);
    drain(0, 4);
    end_test("midrst", 4, 1);
    chk("midrst_first", got_q[0], 72'h64_65_66_68_69_6A_6C_6D_6E);

    do_rst(1);
    begin_test(1'b0);
    send(1, 0, 1'b1, 1'b1, 0, 128);
    drain(1, 8);
    end_test("rand", 84, 1);

    do_rst(2);
    begin_test(1'b1);
    send(2, 0, 1'b0, 1'b0, 0, 9);
    drain(2, 3);
    end_test("min3", 1, 1);
    chk("min3_win", got_q[0], 72'h00_01_02_03_04_05_06_07_08);
    send(2, 50, 1'b0, 1'b1, 0, 9);
    drain(2, 6);
    end_test("min3_f2", 2, 2);
    chk("min3_f2_win", got_q[1], 72'h32_33_34_35_36_37_38_39_3A);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
